// File: rtl/pipeline_pkg.sv
// pipeline_pkg: types and constants shared by the front-end pipeline
// registers (fetch queue, IF/ID, ID/EX).
//   XLEN       - architectural data/address width
//   NOP_INSTR  - canonical bubble instruction, addi x0,x0,0
//   fq_entry_t - one fetched {instr, pc, pc_plus4} triple
package pipeline_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
  } fq_entry_t;

endpackage

// File: rtl/fq_ptr.sv
// fq_ptr: circular-buffer pointer with increment and synchronous clear.
// The pointer wraps naturally from 2**W-1 to 0.
// Ports:
//   clk - clock
//   rst - synchronous active-high reset (pointer to 0)
//   clr - synchronous clear (pointer to 0), e.g. on flush
//   inc - advance the pointer by one
//   ptr - current pointer value
module fq_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: instruction queue between fetch and decode.
// Buffers {instruction, PC, PC+4} triples so fetch keeps running while decode
// stalls. FullF comes from registered state only and drives the PC enable
// (en = ~FullF). A taken branch/jump in execute (FlushQ) discards every entry.
//
// Build option:
//   FETCH_QUEUE_BYPASS_EN - when defined, an instruction arriving at an empty
//   queue is presented to decode in the same cycle (0-cycle latency); it is
//   only written into storage if decode does not take it. When undefined,
//   fetch-to-decode latency is always one cycle, like an IF/ID register.
//
// Ports:
//   clk, rst   - clock, synchronous active-high reset
//   FlushQ     - discard all entries (PCSrcE != 0)
//   EnqValidF  - fetch presents a valid instruction
//   InstrF, PCF, PCPlus4F - fetched triple
//   FullF      - queue full, fetch must hold its PC
//   DeqReadyD  - decode accepts the head entry
//   ValidD     - head entry valid
//   InstrD, PCD, PCPlus4D - head triple (NOP/0/0 when nothing valid)
//   CountQ     - current occupancy
//
// Storage uses pipeline_pkg::fq_entry_t, whose fields are XLEN wide; WIDTH is
// expected to equal XLEN.
module fetch_queue
  import pipeline_pkg::*;
#(
  parameter int               WIDTH = 32,
  parameter int               DEPTH = 4,
  parameter logic [WIDTH-1:0] NOP   = WIDTH'(NOP_INSTR)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       FlushQ,
  input  logic                       EnqValidF,
  input  logic [WIDTH-1:0]           InstrF,
  input  logic [WIDTH-1:0]           PCF,
  input  logic [WIDTH-1:0]           PCPlus4F,
  output logic                       FullF,
  input  logic                       DeqReadyD,
  output logic                       ValidD,
  output logic [WIDTH-1:0]           InstrD,
  output logic [WIDTH-1:0]           PCD,
  output logic [WIDTH-1:0]           PCPlus4D,
  output logic [$clog2(DEPTH+1)-1:0] CountQ
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [CW-1:0] count_q;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          stored_valid;
  logic          enq_ok;
  logic          wr_en;
  logic          rd_en;
  fq_entry_t     wr_entry;
  fq_entry_t     head;

  // NOTE: the entry array has no reset; its contents are don't-care until
  // written and ValidD masks every unwritten slot, so flops stay reset-free.
  fq_entry_t     mem [DEPTH];

  assign stored_valid = (count_q != '0);
  assign FullF        = (count_q == CW'(DEPTH));
  assign CountQ       = count_q;

  // A full queue rejects fetch even if decode drains an entry this cycle;
  // FullF never looks at DeqReadyD, so fetch simply holds its PC.
  assign enq_ok = EnqValidF && !FullF && !FlushQ;
  assign rd_en  = stored_valid && DeqReadyD && !FlushQ;

`ifdef FETCH_QUEUE_BYPASS_EN
  logic bypass;
  // Empty queue: the incoming triple goes straight to decode. If decode takes
  // it, it never occupies a slot.
  assign bypass = !stored_valid && EnqValidF && !FlushQ;
  assign wr_en  = enq_ok && !(bypass && DeqReadyD);
`else
  assign wr_en  = enq_ok;
`endif

  assign wr_entry = '{instr:    XLEN'(InstrF),
                      pc:       XLEN'(PCF),
                      pc_plus4: XLEN'(PCPlus4F)};

  fq_ptr #(.W(AW)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (FlushQ),
    .inc (wr_en),
    .ptr (wr_ptr)
  );

  fq_ptr #(.W(AW)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (FlushQ),
    .inc (rd_en),
    .ptr (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  // Flush drops any same-cycle enqueue/dequeue; the count cannot leave
  // 0..DEPTH because wr_en requires !FullF and rd_en requires a valid entry.
  always_ff @(posedge clk) begin
    if (rst || FlushQ) begin
      count_q <= '0;
    end else begin
      case ({wr_en, rd_en})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  assign head = mem[rd_ptr];

  // NOTE: every output of this block gets a default first, so no path
  // through it leaves a variable unassigned and no latch is inferred.
  always_comb begin
    ValidD   = stored_valid;
    InstrD   = NOP;
    PCD      = '0;
    PCPlus4D = '0;
    if (stored_valid) begin
      InstrD   = WIDTH'(head.instr);
      PCD      = WIDTH'(head.pc);
      PCPlus4D = WIDTH'(head.pc_plus4);
    end
`ifdef FETCH_QUEUE_BYPASS_EN
    else if (bypass) begin
      ValidD   = 1'b1;
      InstrD   = InstrF;
      PCD      = PCF;
      PCPlus4D = PCPlus4F;
    end
`endif
  end

endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed stimulus with a scoreboard for fetch_queue.
// Stimulus pushes the expected {instr, pc, pc+4} for every instruction that
// should reach decode; a monitor pops and compares on every decode handshake.
// Build with +define+FETCH_QUEUE_BYPASS_EN to also cover the bypass path.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        FlushQ = 1'b0;
  logic        EnqValidF = 1'b0;
  logic [31:0] InstrF = '0;
  logic [31:0] PCF = '0;
  logic [31:0] PCPlus4F = '0;
  logic        FullF;
  logic        DeqReadyD = 1'b0;
  logic        ValidD;
  logic [31:0] InstrD;
  logic [31:0] PCD;
  logic [31:0] PCPlus4D;
  logic [2:0]  CountQ;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   n_pop = 0;

  fetch_queue dut (
    .clk       (clk),
    .rst       (rst),
    .FlushQ    (FlushQ),
    .EnqValidF (EnqValidF),
    .InstrF    (InstrF),
    .PCF       (PCF),
    .PCPlus4F  (PCPlus4F),
    .FullF     (FullF),
    .DeqReadyD (DeqReadyD),
    .ValidD    (ValidD),
    .InstrD    (InstrD),
    .PCD       (PCD),
    .PCPlus4D  (PCPlus4D),
    .CountQ    (CountQ)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  function automatic logic [31:0] ins(input logic [31:0] pc);
    return {pc[11:0], 20'h00093};
  endfunction

  // One cycle of stimulus; called at posedge+1, returns at the next posedge+1.
  task automatic step(input bit enq, input logic [31:0] instr, input logic [31:0] pc,
                      input bit rdy, input bit flush, input bit push);
    exp_t e;
    EnqValidF = enq;
    InstrF    = instr;
    PCF       = pc;
    PCPlus4F  = pc + 32'd4;
    DeqReadyD = rdy;
    FlushQ    = flush;
    if (flush) exp_q.delete();
    if (push) begin
      e.instr = instr;
      e.pc    = pc;
      e.pc4   = pc + 32'd4;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    EnqValidF = 1'b0;
    DeqReadyD = 1'b0;
    FlushQ    = 1'b0;
  endtask

  // Monitor: a decode handshake happens at the coming edge whenever the head
  // is valid, decode is ready and no flush is pending.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && ValidD && DeqReadyD && !FlushQ) begin
        n_pop++;
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_out: got pc %h, expected no output", PCD);
        end else begin
          e = exp_q.pop_front();
          check("out_instr", InstrD, e.instr);
          check("out_pc", PCD, e.pc);
          check("out_pc4", PCPlus4D, e.pc4);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  localparam logic [31:0] WRAP_PC [10] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10,
                                           32'h14, 32'h18, 32'h1C, 32'h20, 32'h24};
  localparam bit          WRAP_RDY[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1,
                                           1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  initial begin
    int exp_pops;
    logic [31:0] pc;
    bit rdy;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_valid", ValidD, 32'd0);
    check("rst_instr", InstrD, 32'h00000013);
    check("rst_pc", PCD, 32'd0);
    check("rst_pc4", PCPlus4D, 32'd0);
    check("rst_count", CountQ, 32'd0);
    check("rst_full", FullF, 32'd0);

    // Single pass
    step(1, 32'h00500093, 32'h0, 1, 0, 1);
`ifndef FETCH_QUEUE_BYPASS_EN
    check("single_valid", ValidD, 32'd1);
    check("single_pc", PCD, 32'h0);
    check("single_instr", InstrD, 32'h00500093);
`endif
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("single_after_valid", ValidD, 32'd0);

    // Fill and backpressure: 0x10 must be rejected
    for (int i = 0; i < 4; i++) begin
      pc = 32'(i * 4);
      step(1, ins(pc), pc, 0, 0, 1);
    end
    step(1, ins(32'h10), 32'h10, 0, 0, 0);
    check("fill_count", CountQ, 32'd4);
    check("fill_full", FullF, 32'd1);
    check("fill_head_pc", PCD, 32'h0);
    // Full with a dequeue: the enqueue is still rejected
    step(1, ins(32'h50), 32'h50, 1, 0, 0);
    check("full_deq_count", CountQ, 32'd3);
    check("full_deq_full", FullF, 32'd0);
    repeat (3) step(0, 32'h0, 32'h0, 1, 0, 0);
    check("drain_valid", ValidD, 32'd0);
    check("drain_count", CountQ, 32'd0);
    check("drain_instr", InstrD, 32'h00000013);

    // Wrap-around: interleaved enqueue/dequeue, occupancy kept at 1..3
    for (int i = 0; i < 10; i++) begin
      pc  = WRAP_PC[i];
      rdy = WRAP_RDY[i];
      step(1, ins(pc), pc, rdy, 0, 1);
    end
    check("wrap_count", CountQ, 32'd3);
    repeat (3) step(0, 32'h0, 32'h0, 1, 0, 0);
    check("wrap_drain_count", CountQ, 32'd0);

    // Flush mid-stream with simultaneous enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      pc = 32'h40 + 32'(i * 4);
      step(1, ins(pc), pc, 0, 0, 1);
    end
    check("preflush_count", CountQ, 32'd3);
    step(1, ins(32'h200), 32'h200, 1, 1, 0);
    check("flush_count", CountQ, 32'd0);
    check("flush_valid", ValidD, 32'd0);
    check("flush_instr", InstrD, 32'h00000013);
    step(1, ins(32'h100), 32'h100, 0, 0, 1);
    check("postflush_valid", ValidD, 32'd1);
    check("postflush_pc", PCD, 32'h100);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    // Empty with decode ready: nothing moves
    step(0, 32'h0, 32'h0, 1, 0, 0);
    check("empty_rdy_count", CountQ, 32'd0);
    check("empty_rdy_valid", ValidD, 32'd0);
    step(1, ins(32'h300), 32'h300, 0, 0, 1);
    check("empty_rdy_pc", PCD, 32'h300);
    check("empty_rdy_pc4", PCPlus4D, 32'h304);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    exp_pops = 17;
`ifdef FETCH_QUEUE_BYPASS_EN
    // Bypass: same-cycle visibility, nothing stored
    begin
      exp_t e;
      e.instr = ins(32'h20);
      e.pc    = 32'h20;
      e.pc4   = 32'h24;
      exp_q.push_back(e);
      EnqValidF = 1'b1;
      InstrF    = ins(32'h20);
      PCF       = 32'h20;
      PCPlus4F  = 32'h24;
      DeqReadyD = 1'b1;
      #1;
      check("bypass_valid", ValidD, 32'd1);
      check("bypass_pc", PCD, 32'h20);
      @(posedge clk);
      #1;
      EnqValidF = 1'b0;
      DeqReadyD = 1'b0;
      check("bypass_count", CountQ, 32'd0);
      check("bypass_after_valid", ValidD, 32'd0);
      exp_pops = 18;
    end
`endif

    step(0, 32'h0, 32'h0, 0, 0, 0);
    check("scoreboard_left", exp_q.size(), 32'd0);
    check("output_count", n_pop, exp_pops);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
